// File: rtl/microgreen_feature_acc_pkg.sv
// Shared definitions for the microgreen feature accumulator: channel indices,
// FSM state encoding and the width of one quantised feature field.
package microgreen_feature_acc_pkg;

    // Channel indices as carried on s_ch; also the nibble order in m_features.
    localparam int unsigned CH_HEIGHT = 0;
    localparam int unsigned CH_COLOR  = 1;
    localparam int unsigned CH_WIDTH  = 2;
    localparam int unsigned CH_STEM   = 3;

    localparam int unsigned N_CH   = 4;
    localparam int unsigned CH_W   = 2;
    localparam int unsigned FEAT_W = 4;
    localparam int unsigned FRAME_W = N_CH * FEAT_W;

    typedef enum logic {
        ST_ACCUM = 1'b0,
        ST_EMIT  = 1'b1
    } state_e;

endpackage : microgreen_feature_acc_pkg

// File: rtl/microgreen_feature_acc_if.sv
// Sample-in / frame-out handshake bundle. The master side is the sensor feed
// plus the downstream classifier; the slave side is the accumulator block.
interface microgreen_feature_acc_if
    import microgreen_feature_acc_pkg::*;
#(
    parameter int unsigned SAMPLE_W = 8
);
    logic                s_valid;
    logic                s_ready;
    logic [CH_W-1:0]     s_ch;
    logic [SAMPLE_W-1:0] s_data;
    logic                m_valid;
    logic                m_ready;
    logic [FRAME_W-1:0]  m_features;

    modport master (
        output s_valid, s_ch, s_data, m_ready,
        input  s_ready, m_valid, m_features
    );

    modport slave (
        input  s_valid, s_ch, s_data, m_ready,
        output s_ready, m_valid, m_features
    );

endinterface : microgreen_feature_acc_if

// File: rtl/microgreen_chan_acc.sv
// One sensor channel: running sum, sample counter, full flag and the
// quantised feature of the running average. Next-state views are exported
// so the parent can capture a frame in the same cycle its last sample lands.
module microgreen_chan_acc
    import microgreen_feature_acc_pkg::*;
#(
    parameter int unsigned SAMPLE_W = 8,
    parameter int unsigned AVG_LOG2 = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clear_i,
    input  logic                add_i,
    input  logic [SAMPLE_W-1:0] data_i,
    output logic                full_o,
    output logic                full_nxt_o,
    output logic [FEAT_W-1:0]   feat_nxt_o
);

    localparam int unsigned ACC_W = SAMPLE_W + AVG_LOG2;
    localparam int unsigned CNT_W = AVG_LOG2 + 1;

    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // The counter stops at exactly 2^AVG_LOG2, so its MSB alone marks full.
    assign full_o     = cnt_q[AVG_LOG2];
    assign full_nxt_o = cnt_d[AVG_LOG2];

    // (acc >> AVG_LOG2)[SAMPLE_W-1 -: FEAT_W] is simply the top FEAT_W bits of acc.
    assign feat_nxt_o = acc_d[ACC_W-1 -: FEAT_W];

    // Next-state: clear wins, otherwise add while the channel still has room.
    always_comb begin
        acc_d = acc_q;
        cnt_d = cnt_q;
        if (clear_i) begin
            acc_d = '0;
            cnt_d = '0;
        end else if (add_i && !full_o) begin
            acc_d = acc_q + ACC_W'(data_i);
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Channel state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
            cnt_q <= '0;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
        end
    end

endmodule : microgreen_chan_acc

// File: rtl/microgreen_feature_acc.sv
// Collects 2^AVG_LOG2 samples on each of four sensor channels, then presents
// one packed frame of 4-bit averaged features until the classifier takes it.
// Extra samples for an already-full channel are dropped and counted.
module microgreen_feature_acc
    import microgreen_feature_acc_pkg::*;
#(
    parameter int unsigned SAMPLE_W = 8,
    parameter int unsigned AVG_LOG2 = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    microgreen_feature_acc_if.slave  bus,
    output logic [7:0]               drop_cnt,
    output logic [7:0]               frame_cnt
);

    state_e               state_q;
    logic [FRAME_W-1:0]   m_features_q;
    logic [7:0]           drop_cnt_q;
    logic [7:0]           frame_cnt_q;

    logic                 in_accum;
    logic                 take;
    logic                 chan_clr;
    logic [N_CH-1:0]      add_vec;
    logic [N_CH-1:0]      full_vec;
    logic [N_CH-1:0]      full_nxt_vec;
    logic [FRAME_W-1:0]   feat_nxt;

    assign in_accum = (state_q == ST_ACCUM);

    // A sample is taken only in ACCUM and only when no soft clear is pending.
    assign take = in_accum && bus.s_valid && !clr;

    // Channels are wiped by a soft clear in ACCUM or by frame delivery in EMIT.
    assign chan_clr = in_accum ? clr : bus.m_ready;

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        assign add_vec[g] = take && (bus.s_ch == CH_W'(g));

        microgreen_chan_acc #(
            .SAMPLE_W (SAMPLE_W),
            .AVG_LOG2 (AVG_LOG2)
        ) u_chan (
            .clk        (clk),
            .rst        (rst),
            .clear_i    (chan_clr),
            .add_i      (add_vec[g]),
            .data_i     (bus.s_data),
            .full_o     (full_vec[g]),
            .full_nxt_o (full_nxt_vec[g]),
            .feat_nxt_o (feat_nxt[g*FEAT_W +: FEAT_W])
        );
    end

    assign bus.s_ready    = in_accum;
    assign bus.m_valid    = !in_accum;
    assign bus.m_features = m_features_q;
    assign drop_cnt       = drop_cnt_q;
    assign frame_cnt      = frame_cnt_q;

    // Frame FSM plus the drop/frame counters and the captured feature word.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_ACCUM;
            m_features_q <= '0;
            drop_cnt_q   <= '0;
            frame_cnt_q  <= '0;
        end else begin
            case (state_q)
                ST_ACCUM: begin
                    if (take) begin
                        if (full_vec[bus.s_ch]) begin
                            if (drop_cnt_q != 8'hFF) begin
                                drop_cnt_q <= drop_cnt_q + 8'd1;
                            end
                        end else if (&full_nxt_vec) begin
                            // This sample fills the last open channel.
                            state_q      <= ST_EMIT;
                            m_features_q <= feat_nxt;
                        end
                    end
                end
                ST_EMIT: begin
                    if (bus.m_ready) begin
                        state_q     <= ST_ACCUM;
                        frame_cnt_q <= frame_cnt_q + 8'd1;
                    end
                end
                default: state_q <= ST_ACCUM;
            endcase
        end
    end

endmodule : microgreen_feature_acc

// File: tb/tb_microgreen_feature_acc.sv
// Randomised self-checking bench for microgreen_feature_acc. The reference
// model keeps per-channel sums and counts and derives features arithmetically.
module tb_microgreen_feature_acc;
    import microgreen_feature_acc_pkg::*;

    localparam int SW = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       clr;
    logic [7:0] drop_cnt;
    logic [7:0] frame_cnt;

    microgreen_feature_acc_if #(.SAMPLE_W(SW)) bus ();

    microgreen_feature_acc #(
        .SAMPLE_W (SW),
        .AVG_LOG2 (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .bus       (bus),
        .drop_cnt  (drop_cnt),
        .frame_cnt (frame_cnt)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model state.
    int          m_sum [4];
    int          m_cnt [4];
    int          m_drop;
    int          m_frames;
    bit          m_emit;
    logic [15:0] m_feat;

    int q_ch[$];
    int q_d[$];

    function automatic logic [15:0] model_features();
        logic [15:0] f;
        f = '0;
        for (int c = 0; c < 4; c++) begin
            // average of 4 samples, then keep its upper nibble (divide by 16)
            f[c*4 +: 4] = 4'((m_sum[c] / 4) / 16);
        end
        return f;
    endfunction

    task automatic model_clear();
        for (int c = 0; c < 4; c++) begin
            m_sum[c] = 0;
            m_cnt[c] = 0;
        end
    endtask

    task automatic model_reset();
        model_clear();
        m_drop   = 0;
        m_frames = 0;
        m_emit   = 0;
        m_feat   = '0;
    endtask

    task automatic model_sample(input int ch, input int d);
        bit all_full;
        if (m_emit) return;
        if (m_cnt[ch] == 4) begin
            if (m_drop < 255) m_drop++;
        end else begin
            m_sum[ch] += d;
            m_cnt[ch]++;
            all_full = 1;
            for (int c = 0; c < 4; c++) if (m_cnt[c] != 4) all_full = 0;
            if (all_full) begin
                m_emit = 1;
                m_feat = model_features();
            end
        end
    endtask

    task automatic send(input int ch, input int d);
        bus.s_valid = 1'b1;
        bus.s_ch    = 2'(ch);
        bus.s_data  = 8'(d);
        model_sample(ch, d);
        @(posedge clk);
        #1;
        bus.s_valid = 1'b0;
    endtask

    task automatic handshake();
        bus.m_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.m_ready = 1'b0;
        if (m_emit) begin
            m_emit   = 0;
            m_frames = (m_frames + 1) % 256;
            model_clear();
        end
    endtask

    task automatic play_shuffled();
        for (int i = q_ch.size() - 1; i > 0; i--) begin
            int j;
            int t;
            j = $urandom_range(0, i);
            t = q_ch[i]; q_ch[i] = q_ch[j]; q_ch[j] = t;
            t = q_d[i];  q_d[i]  = q_d[j];  q_d[j]  = t;
        end
        for (int i = 0; i < q_ch.size(); i++) begin
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
            send(q_ch[i], q_d[i]);
        end
        q_ch.delete();
        q_d.delete();
    endtask

    task automatic queue_random_frame();
        for (int c = 0; c < 4; c++) begin
            for (int k = 0; k < 4; k++) begin
                q_ch.push_back(c);
                q_d.push_back(int'($urandom_range(0, 255)));
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        n_cmp++; if (bus.s_ready !== 1'b1) begin n_fail++; $display("FAIL reset_s_ready got %b want 1", bus.s_ready); end
        n_cmp++; if (bus.m_valid !== 1'b0) begin n_fail++; $display("FAIL reset_m_valid got %b want 0", bus.m_valid); end
        n_cmp++; if (bus.m_features !== 16'h0000) begin n_fail++; $display("FAIL reset_features got %h want 0000", bus.m_features); end
        n_cmp++; if (drop_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_drop got %0d want 0", drop_cnt); end
        n_cmp++; if (frame_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_frame got %0d want 0", frame_cnt); end
    endtask

    task automatic test_all_ff();
        bus.m_ready = 1'b1;
        for (int i = 0; i < 16; i++) send(i % 4, 255);
        n_cmp++; if (bus.m_valid !== 1'b1) begin n_fail++; $display("FAIL allff_m_valid got %b want 1", bus.m_valid); end
        n_cmp++; if (bus.m_features !== 16'hFFFF) begin n_fail++; $display("FAIL allff_features got %h want FFFF", bus.m_features); end
        n_cmp++; if (bus.m_features !== m_feat) begin n_fail++; $display("FAIL allff_model got %h want %h", bus.m_features, m_feat); end
        handshake();
        n_cmp++; if (frame_cnt !== 8'd1) begin n_fail++; $display("FAIL allff_frame_cnt got %0d want 1", frame_cnt); end
        n_cmp++; if (bus.m_valid !== 1'b0) begin n_fail++; $display("FAIL allff_after_valid got %b want 0", bus.m_valid); end
    endtask

    task automatic test_averages();
        int avg [4];
        avg[CH_HEIGHT] = 16; avg[CH_COLOR] = 48; avg[CH_WIDTH] = 128; avg[CH_STEM] = 200;
        for (int c = 0; c < 4; c++) begin
            int k1;
            int k2;
            k1 = $urandom_range(0, 15);
            k2 = $urandom_range(0, 15);
            q_ch.push_back(c); q_d.push_back(avg[c] - k1);
            q_ch.push_back(c); q_d.push_back(avg[c] + k1);
            q_ch.push_back(c); q_d.push_back(avg[c] - k2);
            q_ch.push_back(c); q_d.push_back(avg[c] + k2);
        end
        play_shuffled();
        // height average 16 = 8'h10 -> nibble 1; color 3, width 8, stem C
        n_cmp++; if (bus.m_features !== 16'hC831) begin n_fail++; $display("FAIL avg_features got %h want C831", bus.m_features); end
        n_cmp++; if (bus.m_features !== m_feat) begin n_fail++; $display("FAIL avg_model got %h want %h", bus.m_features, m_feat); end
        handshake();
        n_cmp++; if (frame_cnt !== 8'(m_frames)) begin n_fail++; $display("FAIL avg_frame_cnt got %0d want %0d", frame_cnt, m_frames); end
    endtask

    task automatic test_drop();
        for (int k = 0; k < 4; k++) send(CH_HEIGHT, int'($urandom_range(0, 255)));
        send(CH_HEIGHT, 255);
        n_cmp++; if (drop_cnt !== 8'd1) begin n_fail++; $display("FAIL drop_cnt got %0d want 1", drop_cnt); end
        n_cmp++; if (bus.m_valid !== 1'b0) begin n_fail++; $display("FAIL drop_early_valid got %b want 0", bus.m_valid); end
        for (int c = 1; c < 4; c++) begin
            for (int k = 0; k < 4; k++) begin
                q_ch.push_back(c);
                q_d.push_back(int'($urandom_range(0, 255)));
            end
        end
        play_shuffled();
        n_cmp++; if (bus.m_features !== m_feat) begin n_fail++; $display("FAIL drop_features got %h want %h", bus.m_features, m_feat); end
        handshake();
    endtask

    task automatic test_backpressure();
        int frames_before;
        queue_random_frame();
        play_shuffled();
        frames_before = m_frames;
        for (int i = 0; i < 10; i++) begin
            // noise on the sample side and clr must not disturb EMIT
            bus.s_valid = 1'($urandom_range(0, 1));
            bus.s_ch    = 2'($urandom_range(0, 3));
            bus.s_data  = 8'($urandom_range(0, 255));
            clr         = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
            n_cmp++; if (bus.s_ready !== 1'b0) begin n_fail++; $display("FAIL bp_s_ready cyc %0d got %b want 0", i, bus.s_ready); end
            n_cmp++; if (bus.m_valid !== 1'b1) begin n_fail++; $display("FAIL bp_m_valid cyc %0d got %b want 1", i, bus.m_valid); end
            n_cmp++; if (bus.m_features !== m_feat) begin n_fail++; $display("FAIL bp_features cyc %0d got %h want %h", i, bus.m_features, m_feat); end
            n_cmp++; if (frame_cnt !== 8'(frames_before)) begin n_fail++; $display("FAIL bp_frame_cnt cyc %0d got %0d want %0d", i, frame_cnt, frames_before); end
        end
        bus.s_valid = 1'b0;
        clr = 1'b0;
        handshake();
        n_cmp++; if (frame_cnt !== 8'(m_frames)) begin n_fail++; $display("FAIL bp_release_frame got %0d want %0d", frame_cnt, m_frames); end
        n_cmp++; if (bus.s_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready got %b want 1", bus.s_ready); end
        n_cmp++; if (drop_cnt !== 8'(m_drop)) begin n_fail++; $display("FAIL bp_drop got %0d want %0d", drop_cnt, m_drop); end
    endtask

    task automatic test_clr();
        for (int i = 0; i < 7; i++) send(int'($urandom_range(0, 3)), int'($urandom_range(0, 255)));
        clr         = 1'b1;
        bus.s_valid = 1'b1;
        bus.s_ch    = 2'($urandom_range(0, 3));
        bus.s_data  = 8'hFF;
        @(posedge clk);
        #1;
        clr         = 1'b0;
        bus.s_valid = 1'b0;
        model_clear();
        for (int i = 0; i < 16; i++) send(i % 4, 8'h80);
        n_cmp++; if (bus.m_valid !== 1'b1) begin n_fail++; $display("FAIL clr_m_valid got %b want 1", bus.m_valid); end
        n_cmp++; if (bus.m_features !== 16'h8888) begin n_fail++; $display("FAIL clr_features got %h want 8888", bus.m_features); end
        n_cmp++; if (drop_cnt !== 8'(m_drop)) begin n_fail++; $display("FAIL clr_drop got %0d want %0d", drop_cnt, m_drop); end
        handshake();
    endtask

    task automatic test_random_frames();
        for (int f = 0; f < 6; f++) begin
            queue_random_frame();
            for (int e = 0; e < 3; e++) begin
                q_ch.push_back(int'($urandom_range(0, 3)));
                q_d.push_back(int'($urandom_range(0, 255)));
            end
            play_shuffled();
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk);
                #1;
            end
            n_cmp++; if (bus.m_valid !== 1'(m_emit)) begin n_fail++; $display("FAIL rnd_m_valid frame %0d got %b want %b", f, bus.m_valid, m_emit); end
            n_cmp++; if (bus.m_features !== m_feat) begin n_fail++; $display("FAIL rnd_features frame %0d got %h want %h", f, bus.m_features, m_feat); end
            n_cmp++; if (drop_cnt !== 8'(m_drop)) begin n_fail++; $display("FAIL rnd_drop frame %0d got %0d want %0d", f, drop_cnt, m_drop); end
            handshake();
            n_cmp++; if (frame_cnt !== 8'(m_frames)) begin n_fail++; $display("FAIL rnd_frame_cnt frame %0d got %0d want %0d", f, frame_cnt, m_frames); end
        end
    endtask

    task automatic test_drop_saturate();
        for (int k = 0; k < 4; k++) send(CH_STEM, int'($urandom_range(0, 255)));
        for (int k = 0; k < 260; k++) send(CH_STEM, int'($urandom_range(0, 255)));
        n_cmp++; if (drop_cnt !== 8'd255) begin n_fail++; $display("FAIL drop_sat got %0d want 255", drop_cnt); end
        n_cmp++; if (drop_cnt !== 8'(m_drop)) begin n_fail++; $display("FAIL drop_sat_model got %0d want %0d", drop_cnt, m_drop); end
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        model_clear();
        n_cmp++; if (drop_cnt !== 8'd255) begin n_fail++; $display("FAIL drop_after_clr got %0d want 255", drop_cnt); end
    endtask

    task automatic test_rst_emit();
        queue_random_frame();
        play_shuffled();
        n_cmp++; if (bus.m_valid !== 1'b1) begin n_fail++; $display("FAIL rst_pre_valid got %b want 1", bus.m_valid); end
        rst         = 1'b1;
        clr         = 1'b1;
        bus.m_ready = 1'b1;
        @(posedge clk);
        #1;
        rst         = 1'b0;
        clr         = 1'b0;
        bus.m_ready = 1'b0;
        model_reset();
        n_cmp++; if (bus.m_valid !== 1'b0) begin n_fail++; $display("FAIL rst_emit_valid got %b want 0", bus.m_valid); end
        n_cmp++; if (bus.m_features !== 16'h0000) begin n_fail++; $display("FAIL rst_emit_features got %h want 0000", bus.m_features); end
        n_cmp++; if (frame_cnt !== 8'd0) begin n_fail++; $display("FAIL rst_emit_frame got %0d want 0", frame_cnt); end
        n_cmp++; if (drop_cnt !== 8'd0) begin n_fail++; $display("FAIL rst_emit_drop got %0d want 0", drop_cnt); end
        n_cmp++; if (bus.s_ready !== 1'b1) begin n_fail++; $display("FAIL rst_emit_ready got %b want 1", bus.s_ready); end
        // accumulators must also be empty: a fresh 16-sample frame is required
        for (int i = 0; i < 15; i++) send(i % 4, 8'h40);
        n_cmp++; if (bus.m_valid !== 1'b0) begin n_fail++; $display("FAIL rst_emit_partial got %b want 0", bus.m_valid); end
        send(3, 8'h40);
        n_cmp++; if (bus.m_features !== 16'h4444) begin n_fail++; $display("FAIL rst_emit_refill got %h want 4444", bus.m_features); end
        handshake();
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst         = 1'b1;
        clr         = 1'b0;
        bus.s_valid = 1'b0;
        bus.s_ch    = '0;
        bus.s_data  = '0;
        bus.m_ready = 1'b0;
        model_reset();
        test_reset();
        test_all_ff();
        test_averages();
        test_drop();
        test_backpressure();
        test_clr();
        test_random_frames();
        test_drop_saturate();
        test_rst_emit();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_microgreen_feature_acc
